sleep_regulator: RTL and testbench
==================================

SLEEP_REGULATOR -- requirements
Module: sleep_regulator

Interface
REQ-001 Parameter PRESSURE_THRESH, default 12: sleep_pressure value at which AWAKE moves to DROWSY.
REQ-002 Parameter SETTLE_TICKS, default 4: settle count needed in DROWSY to fall asleep.
REQ-003 Parameter MIN_SLEEP_TICKS, default 4: minimum ASLEEP ticks before a natural wake.
REQ-004 Parameter DISTURB_LIMIT, default 3: disturb events in ASLEEP that force a wake.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 tick  in  1  time-base strobe, one cycle wide; all counters advance only on tick.
REQ-008 vital_energy_level  in  2  energy level (00 empty .. 11 full).
REQ-009 tired  in  1  tired stimulus bit.
REQ-010 calm_down  in  1  soothing stimulus.
REQ-011 disturb  in  1  disturbing stimulus (tickle, play or talk combined upstream).
REQ-012 action  in  8  one-hot action from the action regulator; bit 0 means asleep.
REQ-013 sleep_in_signal  out  1  registered one-cycle pulse requesting SLEEP.
REQ-014 wake_up_signal  out  1  registered one-cycle pulse requesting wake.
REQ-015 sleep_pressure  out  4  current sleep pressure, unsigned.
REQ-016 sleep_state  out  2  FSM state: AWAKE=00, DROWSY=01, ASLEEP=10, WAKING=11.

Function
REQ-017 AWAKE: each tick increments sleep_pressure, saturating at 15.
REQ-018 AWAKE -> DROWSY on the first tick where sleep_pressure >= PRESSURE_THRESH or (tired and vital_energy_level == 00); settle counter is cleared.
REQ-019 DROWSY, per tick: disturb clears settle; otherwise calm_down adds 2; otherwise add 1; settle saturates at 7.
REQ-020 If disturb and calm_down occur on the same tick, disturb wins.
REQ-021 DROWSY -> ASLEEP on the edge where settle >= SETTLE_TICKS; sleep_in_signal is high for exactly the next cycle; the sleep tick count, disturb count and confirmed flag are cleared.
REQ-022 ASLEEP, per tick: sleep_pressure decrements, saturating at 0; the sleep tick count increments, saturating at 15.
REQ-023 ASLEEP -> WAKING when sleep_pressure == 0, vital_energy_level == 11 and sleep tick count >= MIN_SLEEP_TICKS.
REQ-024 The confirmed flag sets on any cycle in ASLEEP with action[0] == 1.
REQ-025 If confirmed and action[0] == 0, ASLEEP -> AWAKE directly, with no pulse and sleep_pressure retained.
REQ-026 WAKING lasts exactly one cycle: wake_up_signal is high the following cycle, then AWAKE; a tick during WAKING is ignored.
REQ-027 sleep_in_signal and wake_up_signal are never high in the same cycle, and each is never high for two consecutive cycles.
REQ-028 With tick held low, no counter or state changes except REQ-025 and REQ-026.

Reset
REQ-029 rst_n low asynchronously forces: state AWAKE, sleep_pressure 0, all counters and flags 0, both pulses 0.
REQ-030 Reset mid-operation, including during a pending pulse, drops the pulse; there is no resumption after reset.

Configuration
REQ-031 SLEEP_DISTURB_WAKE_EN defined: in ASLEEP, each tick with disturb increments the disturb count; reaching DISTURB_LIMIT -> WAKING regardless of MIN_SLEEP_TICKS and energy.
REQ-032 SLEEP_DISTURB_WAKE_EN undefined: disturb is ignored in ASLEEP, and no disturb counter logic is synthesized.

Structure
REQ-033 Shared package mimosa_pkg holds the sleep_state encodings, the action one-hot constants (SLEEP=bit0) and the energy level encodings.
REQ-034 One sub-module, sat_counter (width, saturating up/down with clear), is used for pressure, settle, sleep tick and disturb counts.

Verification
REQ-035 Tick every cycle, tired=0, no stimuli: DROWSY after 12 ticks; sleep_in_signal pulses 4 ticks later; sleep_state=10.
REQ-036 DROWSY with disturb on tick 3, then quiet: settle restarts; sleep_in_signal occurs 4 ticks after the disturb.
REQ-037 DROWSY with calm_down on every tick: ASLEEP after 2 ticks.
REQ-038 ASLEEP, pressure 12, energy=11: wake_up_signal one cycle after pressure reaches 0 (tick 12); sleep_state returns to 00.
REQ-039 With SLEEP_DISTURB_WAKE_EN, 3 disturb ticks 1 tick after sleep: wake_up_signal pulses; without the macro: no wake.
REQ-040 ASLEEP, confirmed, action changes 0x01 -> 0x40: sleep_state=00 next cycle, no pulses, pressure unchanged; rst_n low mid-DROWSY: all outputs 0 immediately.

Source files
------------

// File: rtl/mimosa_pkg.sv
// Shared encodings for the mimosa regulators: sleep FSM states, action one-hot
// constants and vital energy levels.
package mimosa_pkg;

  typedef enum logic [1:0] {
    ST_AWAKE  = 2'b00,
    ST_DROWSY = 2'b01,
    ST_ASLEEP = 2'b10,
    ST_WAKING = 2'b11
  } sleep_state_e;

  localparam logic [7:0] ACT_SLEEP = 8'h01;

  localparam logic [1:0] ENERGY_EMPTY = 2'b00;
  localparam logic [1:0] ENERGY_FULL  = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with synchronous clear; o_next exposes the value
// that will be loaded on the coming edge so callers can decide on it.
module sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_up,
  input  logic             i_down,
  input  logic [WIDTH-1:0] i_step,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_next
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = r_count;
    if (i_clr) begin
      w_next = '0;
    end else if (i_up) begin
      w_next = (r_count > MAX_VAL - i_step) ? MAX_VAL : r_count + i_step;
    end else if (i_down) begin
      w_next = (r_count < i_step) ? '0 : r_count - i_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign o_count = r_count;
  assign o_next  = w_next;

endmodule

// File: rtl/sleep_regulator.sv
// Sleep/wake regulator: tick-driven AWAKE/DROWSY/ASLEEP/WAKING FSM with
// registered sleep/wake pulses. Optional SLEEP_DISTURB_WAKE_EN adds forced wake on repeated disturbs.
module sleep_regulator
  import mimosa_pkg::*;
#(
  parameter int PRESSURE_THRESH = 12,
  parameter int SETTLE_TICKS    = 4,
  parameter int MIN_SLEEP_TICKS = 4,
  parameter int DISTURB_LIMIT   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [1:0] vital_energy_level,
  input  logic       tired,
  input  logic       calm_down,
  input  logic       disturb,
  input  logic [7:0] action,
  output logic       sleep_in_signal,
  output logic       wake_up_signal,
  output logic [3:0] sleep_pressure,
  output logic [1:0] sleep_state
);

  localparam logic [3:0] P_THRESH    = 4'(PRESSURE_THRESH);
  localparam logic [2:0] P_SETTLE    = 3'(SETTLE_TICKS);
  localparam logic [3:0] P_MIN_SLEEP = 4'(MIN_SLEEP_TICKS);

  sleep_state_e r_state, w_state_next;
  logic         r_confirmed, r_sleep_in, r_wake_up;
  logic         w_act_sleep, w_abort;
  logic         w_awake_tick, w_drowsy_tick, w_asleep_tick;
  logic         w_go_drowsy, w_go_asleep, w_natural_wake, w_disturb_wake;
  logic [3:0]   w_pressure, w_pressure_next, w_ticks_cnt, w_ticks_next;
  logic [2:0]   w_settle_cnt, w_settle_next;
  logic         w_unused_counts;

  assign w_act_sleep   = |(action & ACT_SLEEP);
  // Confirmed sleep that loses the sleep action aborts straight to AWAKE and freezes counters.
  assign w_abort       = (r_state == ST_ASLEEP) && r_confirmed && !w_act_sleep;
  assign w_awake_tick  = tick && (r_state == ST_AWAKE);
  assign w_drowsy_tick = tick && (r_state == ST_DROWSY);
  assign w_asleep_tick = tick && (r_state == ST_ASLEEP) && !w_abort;

  sat_counter #(.WIDTH(4)) u_pressure (
    .clk(clk), .rst_n(rst_n), .i_clr(1'b0), .i_up(w_awake_tick), .i_down(w_asleep_tick),
    .i_step(4'd1), .o_count(w_pressure), .o_next(w_pressure_next)
  );

  assign w_go_drowsy = w_awake_tick &&
                       ((w_pressure_next >= P_THRESH) ||
                        (tired && (vital_energy_level == ENERGY_EMPTY)));

  sat_counter #(.WIDTH(3)) u_settle (
    .clk(clk), .rst_n(rst_n), .i_clr(w_go_drowsy || (w_drowsy_tick && disturb)),
    .i_up(w_drowsy_tick && !disturb), .i_down(1'b0),
    .i_step(calm_down ? 3'd2 : 3'd1), .o_count(w_settle_cnt), .o_next(w_settle_next)
  );

  assign w_go_asleep = w_drowsy_tick && (w_settle_next >= P_SETTLE);

  sat_counter #(.WIDTH(4)) u_sleep_ticks (
    .clk(clk), .rst_n(rst_n), .i_clr(w_go_asleep), .i_up(w_asleep_tick), .i_down(1'b0),
    .i_step(4'd1), .o_count(w_ticks_cnt), .o_next(w_ticks_next)
  );

  assign w_natural_wake = w_asleep_tick && (w_pressure_next == 4'd0) &&
                          (vital_energy_level == ENERGY_FULL) && (w_ticks_next >= P_MIN_SLEEP);
  assign w_unused_counts = ^{w_settle_cnt, w_ticks_cnt};

`ifdef SLEEP_DISTURB_WAKE_EN
  localparam logic [3:0] P_DISTURB_LIMIT = 4'(DISTURB_LIMIT);
  logic [3:0] w_disturb_cnt, w_disturb_next;
  logic       w_unused_disturb;

  sat_counter #(.WIDTH(4)) u_disturb (
    .clk(clk), .rst_n(rst_n), .i_clr(w_go_asleep), .i_up(w_asleep_tick && disturb),
    .i_down(1'b0), .i_step(4'd1), .o_count(w_disturb_cnt), .o_next(w_disturb_next)
  );

  assign w_disturb_wake   = w_asleep_tick && (w_disturb_next >= P_DISTURB_LIMIT);
  assign w_unused_disturb = ^w_disturb_cnt;
`else
  logic w_unused_disturb;
  assign w_disturb_wake   = 1'b0;
  assign w_unused_disturb = (DISTURB_LIMIT != 0);
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_AWAKE:  if (w_go_drowsy) w_state_next = ST_DROWSY;
      ST_DROWSY: if (w_go_asleep) w_state_next = ST_ASLEEP;
      ST_ASLEEP: begin
        if (w_abort) begin
          w_state_next = ST_AWAKE;
        end else if (w_natural_wake || w_disturb_wake) begin
          w_state_next = ST_WAKING;
        end
      end
      ST_WAKING: w_state_next = ST_AWAKE;
      default:   w_state_next = ST_AWAKE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_AWAKE;
      r_confirmed <= 1'b0;
      r_sleep_in  <= 1'b0;
      r_wake_up   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sleep_in <= w_go_asleep;
      r_wake_up  <= (r_state == ST_WAKING);
      if (w_go_asleep) begin
        r_confirmed <= 1'b0;
      end else if ((r_state == ST_ASLEEP) && w_act_sleep) begin
        r_confirmed <= 1'b1;
      end
    end
  end

  assign sleep_in_signal = r_sleep_in;
  assign wake_up_signal  = r_wake_up;
  assign sleep_pressure  = w_pressure;
  assign sleep_state     = r_state;

endmodule

// File: tb/tb_sleep_regulator.sv
// Self-checking bench for sleep_regulator: directed scenarios plus randomized
// stimulus compared against a behavioural model of the sleep/wake rules.
module tb_sleep_regulator;

  localparam int THRESH    = 12;
  localparam int SETTLE    = 4;
  localparam int MIN_SLEEP = 4;
  localparam int LIMIT     = 3;
`ifdef SLEEP_DISTURB_WAKE_EN
  localparam bit DW_EN = 1'b1;
`else
  localparam bit DW_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] vital_energy_level = 2'b00;
  logic       tired = 1'b0;
  logic       calm_down = 1'b0;
  logic       disturb = 1'b0;
  logic [7:0] action = 8'h00;
  logic       sleep_in_signal, wake_up_signal;
  logic [3:0] sleep_pressure;
  logic [1:0] sleep_state;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sleep_regulator #(
    .PRESSURE_THRESH(THRESH), .SETTLE_TICKS(SETTLE),
    .MIN_SLEEP_TICKS(MIN_SLEEP), .DISTURB_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .vital_energy_level(vital_energy_level),
    .tired(tired), .calm_down(calm_down), .disturb(disturb), .action(action),
    .sleep_in_signal(sleep_in_signal), .wake_up_signal(wake_up_signal),
    .sleep_pressure(sleep_pressure), .sleep_state(sleep_state)
  );

  // Behavioural model: 0 awake, 1 drowsy, 2 asleep, 3 waking
  int m_state, m_press, m_settle, m_ticks, m_dist;
  bit m_conf, m_sp, m_wp;

  task automatic model_reset();
    m_state = 0; m_press = 0; m_settle = 0; m_ticks = 0; m_dist = 0;
    m_conf = 0; m_sp = 0; m_wp = 0;
  endtask

  task automatic model_step();
    int nxt;
    bit sp, wp;
    nxt = m_state; sp = 0; wp = 0;
    case (m_state)
      0: if (tick) begin
        m_press = (m_press < 15) ? m_press + 1 : 15;
        if (m_press >= THRESH || (tired && vital_energy_level == 2'b00)) begin
          nxt = 1; m_settle = 0;
        end
      end
      1: if (tick) begin
        if (disturb) m_settle = 0;
        else m_settle = (m_settle + (calm_down ? 2 : 1) > 7) ? 7 : m_settle + (calm_down ? 2 : 1);
        if (m_settle >= SETTLE) begin
          nxt = 2; sp = 1; m_ticks = 0; m_dist = 0; m_conf = 0;
        end
      end
      2: begin
        if (m_conf && !action[0]) begin
          nxt = 0;
        end else begin
          if (action[0]) m_conf = 1;
          if (tick) begin
            m_press = (m_press > 0) ? m_press - 1 : 0;
            m_ticks = (m_ticks < 15) ? m_ticks + 1 : 15;
            if (DW_EN && disturb) m_dist = (m_dist < 15) ? m_dist + 1 : 15;
            if ((m_press == 0 && vital_energy_level == 2'b11 && m_ticks >= MIN_SLEEP) ||
                (DW_EN && m_dist >= LIMIT)) nxt = 3;
          end
        end
      end
      default: begin
        nxt = 0; wp = 1;
      end
    endcase
    m_state = nxt; m_sp = sp; m_wp = wp;
  endtask

  function automatic logic [7:0] model_out();
    return {2'(m_state), 4'(m_press), m_sp, m_wp};
  endfunction

  function automatic logic [7:0] dut_out();
    return {sleep_state, sleep_pressure, sleep_in_signal, wake_up_signal};
  endfunction

  task automatic step();
    if (!rst_n) model_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic t, input logic [1:0] e, input logic ti,
                        input logic c, input logic d, input logic [7:0] a);
    tick = t; vital_energy_level = e; tired = ti; calm_down = c; disturb = d; action = a;
  endtask

  task automatic apply_reset();
    set_in(0, 2'b00, 0, 0, 0, 8'h00);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1, 2'b00, 1, 1, 1, 8'h01);
    step();
    step();
    total++;
    if (dut_out() !== 8'h00) begin
      bad++; $display("FAIL reset_outputs: got %h expected %h", dut_out(), 8'h00);
    end
    rst_n = 1'b1;
    set_in(0, 2'b00, 0, 0, 0, 8'h00);
    step();
    total++;
    if (dut_out() !== model_out()) begin
      bad++; $display("FAIL reset_idle: got %h expected %h", dut_out(), model_out());
    end
    $display("test_reset complete");
  endtask

  task automatic test_natural_cycle();
    apply_reset();
    set_in(1, 2'b11, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 32; i++) begin
      step();
      total++;
      if (dut_out() !== model_out()) begin
        bad++; $display("FAIL natural_cycle tick %0d: got %h expected %h", i, dut_out(), model_out());
      end
      if (i == 11 || i == 12 || i == 15) begin
        total++;
        if (sleep_state !== ((i == 11) ? 2'b00 : 2'b01)) begin
          bad++; $display("FAIL drowsy_entry tick %0d: state %b", i, sleep_state);
        end
      end
      if (i == 16) begin
        total++;
        if ({sleep_state, sleep_in_signal} !== 3'b101) begin
          bad++; $display("FAIL sleep_pulse: got %b expected 101", {sleep_state, sleep_in_signal});
        end
      end
      if (i == 28) begin
        total++;
        if ({sleep_state, sleep_pressure, wake_up_signal} !== 7'b11_0000_0) begin
          bad++; $display("FAIL waking_entry: got %b expected 1100000", {sleep_state, sleep_pressure, wake_up_signal});
        end
      end
      if (i == 29) begin
        total++;
        if ({sleep_state, sleep_pressure, wake_up_signal} !== 7'b00_0000_1) begin
          bad++; $display("FAIL wake_pulse: got %b expected 0000001", {sleep_state, sleep_pressure, wake_up_signal});
        end
      end
    end
    $display("test_natural_cycle complete");
  endtask

  task automatic test_drowsy_disturb();
    apply_reset();
    set_in(1, 2'b00, 1, 0, 0, 8'h00);
    step();
    total++;
    if ({sleep_state, sleep_pressure} !== 6'b01_0001) begin
      bad++; $display("FAIL tired_entry: got %b expected 010001", {sleep_state, sleep_pressure});
    end
    for (int i = 1; i <= 7; i++) begin
      set_in(1, 2'b11, 0, 0, (i == 3), 8'h00);
      step();
      total++;
      if (dut_out() !== model_out()) begin
        bad++; $display("FAIL drowsy_disturb tick %0d: got %h expected %h", i, dut_out(), model_out());
      end
      if (i == 6 || i == 7) begin
        total++;
        if ({sleep_state, sleep_in_signal} !== ((i == 6) ? 3'b010 : 3'b101)) begin
          bad++; $display("FAIL settle_restart tick %0d: got %b", i, {sleep_state, sleep_in_signal});
        end
      end
    end
    $display("test_drowsy_disturb complete");
  endtask

  task automatic test_calm();
    apply_reset();
    set_in(1, 2'b00, 1, 0, 0, 8'h00);
    step();
    for (int i = 1; i <= 2; i++) begin
      set_in(1, 2'b00, 0, 1, 0, 8'h00);
      step();
      total++;
      if ({sleep_state, sleep_in_signal} !== ((i == 1) ? 3'b010 : 3'b101)) begin
        bad++; $display("FAIL calm_settle tick %0d: got %b", i, {sleep_state, sleep_in_signal});
      end
    end
    $display("test_calm complete");
  endtask

  task automatic test_confirm_abort();
    apply_reset();
    set_in(1, 2'b00, 1, 0, 0, 8'h00);
    step();
    set_in(1, 2'b11, 0, 1, 0, 8'h00);
    step();
    step();
    set_in(0, 2'b11, 0, 0, 0, 8'h01);
    step();
    step();
    total++;
    if (sleep_state !== 2'b10) begin
      bad++; $display("FAIL confirmed_hold: state %b expected 10", sleep_state);
    end
    action = 8'h40;
    step();
    total++;
    if (dut_out() !== {2'b00, 4'd1, 2'b00}) begin
      bad++; $display("FAIL abort_wake: got %h expected %h", dut_out(), {2'b00, 4'd1, 2'b00});
    end
    step();
    total++;
    if (dut_out() !== model_out()) begin
      bad++; $display("FAIL abort_after: got %h expected %h", dut_out(), model_out());
    end
    $display("test_confirm_abort complete");
  endtask

  task automatic test_asleep_disturb();
    apply_reset();
    set_in(1, 2'b00, 1, 0, 0, 8'h00);
    step();
    set_in(1, 2'b00, 0, 1, 0, 8'h00);
    step();
    step();
    set_in(1, 2'b00, 0, 0, 0, 8'h00);
    step();
    for (int i = 1; i <= 3; i++) begin
      set_in(1, 2'b00, 0, 0, 1, 8'h00);
      step();
      total++;
      if (dut_out() !== model_out()) begin
        bad++; $display("FAIL asleep_disturb tick %0d: got %h expected %h", i, dut_out(), model_out());
      end
    end
    total++;
    if (sleep_state !== (DW_EN ? 2'b11 : 2'b10)) begin
      bad++; $display("FAIL disturb_limit: state %b expected %b", sleep_state, (DW_EN ? 2'b11 : 2'b10));
    end
    set_in(0, 2'b00, 0, 0, 0, 8'h00);
    step();
    total++;
    if ({sleep_state, wake_up_signal} !== (DW_EN ? 3'b001 : 3'b100)) begin
      bad++; $display("FAIL disturb_wake: got %b expected %b", {sleep_state, wake_up_signal}, (DW_EN ? 3'b001 : 3'b100));
    end
    $display("test_asleep_disturb complete");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_in(1, 2'b00, 1, 0, 0, 8'h00);
    step();
    set_in(1, 2'b00, 0, 0, 0, 8'h00);
    step();
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (dut_out() !== 8'h00) begin
      bad++; $display("FAIL reset_mid_drowsy: got %h expected 00", dut_out());
    end
    step();
    rst_n = 1'b1;
    set_in(1, 2'b00, 1, 0, 0, 8'h00);
    step();
    set_in(1, 2'b00, 0, 1, 0, 8'h00);
    step();
    step();
    total++;
    if (sleep_in_signal !== 1'b1) begin
      bad++; $display("FAIL pending_pulse: got %b expected 1", sleep_in_signal);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (dut_out() !== 8'h00) begin
      bad++; $display("FAIL reset_drops_pulse: got %h expected 00", dut_out());
    end
    step();
    rst_n = 1'b1;
    set_in(0, 2'b00, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (dut_out() !== 8'h00) begin
        bad++; $display("FAIL no_resume %0d: got %h expected 00", i, dut_out());
      end
    end
    $display("test_reset_mid complete");
  endtask

  task automatic test_random();
    bit prev_sp, prev_wp;
    apply_reset();
    prev_sp = 0; prev_wp = 0;
    for (int i = 0; i < 3000; i++) begin
      tick = ($urandom_range(0, 3) != 0);
      vital_energy_level = 2'($urandom_range(0, 3));
      tired = ($urandom_range(0, 3) == 0);
      calm_down = ($urandom_range(0, 2) == 0);
      disturb = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) action = 8'h01;
        else action = 8'h01 << $urandom_range(1, 7);
      end
      step();
      total++;
      if (dut_out() !== model_out()) begin
        bad++; $display("FAIL random cycle %0d: got %h expected %h", i, dut_out(), model_out());
      end
      total++;
      if ((sleep_in_signal && wake_up_signal) || (sleep_in_signal && prev_sp) ||
          (wake_up_signal && prev_wp)) begin
        bad++; $display("FAIL pulse_rules cycle %0d: sp=%b wp=%b prev_sp=%b prev_wp=%b expected isolated pulses",
                        i, sleep_in_signal, wake_up_signal, prev_sp, prev_wp);
      end
      prev_sp = sleep_in_signal;
      prev_wp = wake_up_signal;
    end
    $display("test_random complete");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_natural_cycle();
    test_drowsy_disturb();
    test_calm();
    test_confirm_abort();
    test_asleep_disturb();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
